// File: rtl/mem_arbiter_if.sv
// Memory-side bus of the unified instruction/data memory port.
// The arbiter drives the request fields (master); the memory answers with data and ack (slave).
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          mem_req;
    logic          mem_we;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    modport master (
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and Memory-stage data access onto one variable-latency
// memory port, with alternating priority under contention, per-requester stalls and a timeout abort.
module mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int CW      = 8,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_valid,
    output logic [DW-1:0] i_rdata,
    output logic          i_stall,

    input  logic          d_req,
    input  logic          d_we,
    input  logic [3:0]    d_be,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_valid,
    output logic [DW-1:0] d_rdata,
    output logic          d_stall,

    mem_arbiter_if.master bus,

    output logic          err,
    output logic          err_src
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY_I = 2'd1;
    localparam logic [1:0] BUSY_D = 2'd2;

    localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT);

    logic [1:0]    state;
    logic          last_gnt;
    logic [CW-1:0] cnt;

    logic pend_i;
    logic pend_d;
    logic grant_i;
    logic grant_d;
    logic is_d;
    logic timeout;

    // A request is not pending during its own valid cycle, so a held req is not re-granted.
    assign pend_i  = i_req & ~i_valid;
    assign pend_d  = d_req & ~d_valid;
    assign i_stall = pend_i;
    assign d_stall = pend_d;

    assign is_d    = (state == BUSY_D);
    assign timeout = ((cnt + CW'(1)) == TO_LIM);

    always_comb begin
        // NOTE: defaults first so every path assigns both grants; otherwise a latch is inferred.
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (pend_d && (!pend_i || !last_gnt)) begin
            grant_d = 1'b1;
        end else if (pend_i) begin
            grant_i = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            last_gnt      <= 1'b0;
            cnt           <= '0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_be    <= 4'h0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            i_valid       <= 1'b0;
            i_rdata       <= '0;
            d_valid       <= 1'b0;
            d_rdata       <= '0;
            err           <= 1'b0;
            err_src       <= 1'b0;
        end else begin
            i_valid     <= 1'b0;
            d_valid     <= 1'b0;
            bus.mem_req <= 1'b0;

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (grant_d) begin
                        state         <= BUSY_D;
                        last_gnt      <= 1'b1;
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= d_we;
                        bus.mem_be    <= d_we ? d_be : 4'hF;
                        bus.mem_addr  <= d_addr;
                        bus.mem_wdata <= d_wdata;
                    end else if (grant_i) begin
                        state         <= BUSY_I;
                        last_gnt      <= 1'b0;
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= 1'b0;
                        bus.mem_be    <= 4'hF;
                        bus.mem_addr  <= i_addr;
                        bus.mem_wdata <= '0;
                    end
                end

                BUSY_I, BUSY_D: begin
                    // An ack in the timeout cycle still completes normally.
                    if (bus.mem_ack || timeout) begin
                        state <= IDLE;
                        if (is_d) begin
                            d_valid <= 1'b1;
                            d_rdata <= (bus.mem_ack && !bus.mem_we) ? bus.mem_rdata : '0;
                        end else begin
                            i_valid <= 1'b1;
                            i_rdata <= bus.mem_ack ? bus.mem_rdata : '0;
                        end
                        if (!bus.mem_ack) begin
                            err     <= 1'b1;
                            err_src <= is_d;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares one single-port, variable-latency unified memory between the instruction-fetch stage and the Memory-stage data access of the five-stage RISC-V pipeline. It arbitrates between the two requesters, sequences each transfer through a request/acknowledge memory handshake, and returns read data with a valid pulse. It also drives per-requester stall signals to the hazard logic and detects memory timeouts.

Parameters:
AW, 32, address width
DW, 32, data width
CW, 8, timeout counter width
TIMEOUT, 255, maximum BUSY cycles without mem_ack before abort; legal range 1 to 2^CW-1

Ports:
clk  in  1  clock; all logic on the rising edge
rst  in  1  synchronous, active-high reset
i_req  in  1  fetch request; held high with i_addr stable until i_valid
i_addr  in  AW  fetch address
i_valid  out  1  one-cycle pulse: fetch complete
i_rdata  out  DW  fetched instruction; meaningful while i_valid=1
i_stall  out  1  fetch stage must stall
d_req  in  1  data request (driven from memen_M); held with d_* stable until d_valid
d_we  in  1  write (memwrite_M)
d_be  in  4  byte enables for writes
d_addr  in  AW  data address
d_wdata  in  DW  store data
d_valid  out  1  one-cycle pulse: data access complete
d_rdata  out  DW  load data; 0 after a write
d_stall  out  1  Memory stage must stall
mem_req  out  1  one-cycle request pulse to memory
mem_we  out  1  write strobe qualifier
mem_be  out  4  byte enables (4'hF on reads)
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid with mem_ack
mem_ack  in  1  one-cycle completion from memory
err  out  1  sticky timeout flag
err_src  out  1  requester of the last timeout: 0 = fetch, 1 = data

Behaviour:
- FSM states: IDLE, BUSY_I, BUSY_D. Register last_gnt (0 = I, 1 = D).
- Reset values: state IDLE, last_gnt 0, counter 0. All outputs 0: mem_*, i_valid, d_valid, i_rdata, d_rdata, err, err_src.
- Pending in IDLE: pend_i = i_req & ~i_valid; pend_d = d_req & ~d_valid. This masks the old request during its own valid cycle.
- Arbitration in IDLE:
  - Only one requester pending: grant it.
  - Both pending: grant the one not equal to last_gnt, so after reset D wins first and the two alternate under contention.
  - Neither pending: stay in IDLE.
- Grant, at the edge ending the IDLE cycle:
  - Enter BUSY_x and update last_gnt.
  - Register mem_addr, mem_we (d_we for D, 0 for I), mem_be (d_be for a D write, otherwise 4'hF) and mem_wdata.
  - mem_req=1 for the first BUSY cycle only. The mem_* fields hold stable through all of BUSY.
- BUSY_x: counter clears on entry and increments each BUSY cycle. mem_ack may arrive in any BUSY cycle, including the first.
- mem_ack in BUSY_x:
  - Next cycle: state IDLE, x_valid=1 for exactly one cycle.
  - x_rdata = mem_rdata captured at the ack, or 0 for a D write.
  - rdata holds until the next completion.
- Timeout: counter reaches TIMEOUT in BUSY_x with no ack, so TIMEOUT BUSY cycles in total.
  - Next cycle: state IDLE, x_valid pulses, x_rdata=0, err<=1 (sticky until rst), err_src<=x.
  - If ack and timeout occur in the same cycle, ack wins and there is no error.
- mem_ack outside BUSY (stray or late) is ignored. It has no effect on state or outputs.
- Stalls, combinational: i_stall = i_req & ~i_valid; d_stall = d_req & ~d_valid.
- Latency: request seen in IDLE at cycle 0, mem_req at cycle 1, ack at cycle 1+k (k≥0), valid at cycle 2+k. Best case is 2 cycles.
- Throughput: a new grant can occur in the valid cycle, so back-to-back transfers cost 2+k cycles each.
- rst mid-transfer: returns to IDLE immediately and the transfer is abandoned with no valid pulse. Requesters that still hold req are re-arbitrated after reset.

Test Plan:
- Fetch read, ack in first BUSY cycle: i_req=1, i_addr=0x100, mem_rdata=0x00500093 → mem_req at cycle 1 with mem_addr=0x100, i_valid at cycle 2, i_rdata=0x00500093, i_stall high for cycles 0–1.
- Simultaneous i_req and d_req after reset, both held:
  - Grants go D, I, D, I.
  - d_valid precedes i_valid.
  - Neither requester waits more than one foreign transfer.
- Store: d_we=1, d_be=4'b0011, d_addr=0x2004, d_wdata=0xDEADBEEF, ack after 3 wait cycles → mem_we=1, mem_be=4'b0011, fields held for 4 BUSY cycles, d_valid at cycle 5, d_rdata=0.
- Timeout with TIMEOUT=4: d_req read and mem_ack never asserted → abort after 4 BUSY cycles, d_valid pulses with d_rdata=0, err=1, err_src=1. A later fetch completes normally with err still 1.
- Ack coincident with the timeout cycle → no error, data returned. A stray mem_ack in IDLE → no valid pulse, no state change.
- rst asserted in BUSY_I → next cycle IDLE with all outputs 0. No i_valid for the abandoned fetch; a late mem_ack is ignored; the held i_req is regranted.
